covariance_estimator: RTL and testbench

- Streams SIZE_N-channel fixed-point ECG samples over one frame of 2^LOG2_SAMPLES samples.
- Accumulates per-channel sums and channel-pair product sums, then computes the full symmetric covariance matrix.
- Sits directly upstream of eigenvalue_decomposition. Its cov_mat/f pair drives that block's mat input and start/handshake.

---
 rtl/ecg_pkg.sv | 21 ++
 rtl/cov_element_calc.sv | 55 +++++
 rtl/covariance_estimator.sv | 179 +++++++++++++++++
 tb/tb_covariance_estimator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared ECG chain types: sample and covariance element types, default
// dimensions and the covariance estimator state encoding.
package ecg_pkg;

    localparam int ECG_SIZE_N       = 8;
    localparam int ECG_DATA_W       = 16;
    localparam int ECG_LOG2_SAMPLES = 10;
    localparam int ECG_FRAC_BITS    = 16;
    localparam int ECG_COV_W        = 57;

    typedef logic signed [ECG_DATA_W-1:0] sample_t;
    typedef logic signed [ECG_COV_W-1:0]  cov_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINAL,
        ST_DONE
    } cov_state_e;

endpackage

// File: rtl/cov_element_calc.sv
// Registered finalize of one covariance element:
// ((N*Sxy - Sx_i*Sx_j) << FRAC_BITS) >>> (2*LOG2_SAMPLES), floor rounding.
module cov_element_calc #(
    parameter int IDX_W        = 3,
    parameter int SX_W         = 26,
    parameter int SXY_W        = 42,
    parameter int LOG2_SAMPLES = 10,
    parameter int FRAC_BITS    = 16,
    parameter int COV_W        = 57
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic                    last_i,
    input  logic [IDX_W-1:0]        row_i,
    input  logic [IDX_W-1:0]        col_i,
    input  logic signed [SX_W-1:0]  sx_row_i,
    input  logic signed [SX_W-1:0]  sx_col_i,
    input  logic signed [SXY_W-1:0] sxy_i,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [IDX_W-1:0]        row_o,
    output logic [IDX_W-1:0]        col_o,
    output logic signed [COV_W-1:0] cov_o
);

    localparam int PROD_W = 2 * SX_W;
    localparam int INT_W  = 2 * SX_W + FRAC_BITS + 1;

    logic signed [PROD_W-1:0] sx_sq;
    logic signed [INT_W-1:0]  diff;

    assign sx_sq = PROD_W'(sx_row_i) * PROD_W'(sx_col_i);
    assign diff  = (INT_W'(sxy_i) <<< LOG2_SAMPLES) - INT_W'(sx_sq);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            row_o   <= '0;
            col_o   <= '0;
            cov_o   <= '0;
        end else begin
            valid_o <= valid_i;
            last_o  <= valid_i && last_i;
            if (valid_i) begin
                row_o <= row_i;
                col_o <= col_i;
                cov_o <= COV_W'((diff <<< FRAC_BITS) >>> (2 * LOG2_SAMPLES));
            end
        end
    end

endmodule

// File: rtl/covariance_estimator.sv
// Frame-based covariance estimator: accumulates channel sums and pair products,
// then walks the upper triangle through one shared finalize unit.
module covariance_estimator
    import ecg_pkg::*;
#(
    parameter int SIZE_N       = ECG_SIZE_N,
    parameter int DATA_W       = ECG_DATA_W,
    parameter int LOG2_SAMPLES = ECG_LOG2_SAMPLES,
    parameter int FRAC_BITS    = ECG_FRAC_BITS,
    parameter int COV_W        = ECG_COV_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SIZE_N-1:0][DATA_W-1:0]          in_sample,
    output logic [SIZE_N-1:0][SIZE_N-1:0][COV_W-1:0] cov_mat,
    output logic                                   cov_valid,
    output logic                                   f
);

    localparam int IDX_W  = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int SX_W   = DATA_W + LOG2_SAMPLES;
    localparam int SXY_W  = 2 * DATA_W + LOG2_SAMPLES;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_N - 1);

    if (COV_W < 2 * DATA_W + FRAC_BITS + 1) begin : g_cov_w_check
        $error("COV_W too narrow for the covariance range");
    end

    cov_state_e                              state_q;
    logic                                    in_ready_q;
    logic                                    cov_valid_q;
    logic                                    f_q;
    logic                                    issue_q;
    logic                                    done_pend_q;
    logic [LOG2_SAMPLES-1:0]                 cnt_q;
    logic [IDX_W-1:0]                        row_q;
    logic [IDX_W-1:0]                        col_q;
    logic signed [SX_W-1:0]                  sx_q  [SIZE_N];
    logic signed [SXY_W-1:0]                 sxy_q [SIZE_N][SIZE_N];
    logic [SIZE_N-1:0][SIZE_N-1:0][COV_W-1:0] cov_mat_q;

    logic signed [DATA_W-1:0] x [SIZE_N];
    logic                     xfer;
    logic                     frame_clear;
    logic                     issue_last;
    logic                     el_valid;
    logic                     el_last;
    logic [IDX_W-1:0]         el_row;
    logic [IDX_W-1:0]         el_col;
    logic signed [COV_W-1:0]  el_cov;

    always_comb begin
        for (int i = 0; i < SIZE_N; i++) x[i] = in_sample[i];
    end

    assign xfer        = in_valid && in_ready_q;
    assign frame_clear = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issue_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            cov_valid_q <= 1'b0;
            f_q         <= 1'b0;
            issue_q     <= 1'b0;
            done_pend_q <= 1'b0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            f_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_ACCUM;
                        in_ready_q  <= 1'b1;
                        cov_valid_q <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + LOG2_SAMPLES'(1);
                        if (&cnt_q) begin
                            state_q    <= ST_FINAL;
                            in_ready_q <= 1'b0;
                            issue_q    <= 1'b1;
                            row_q      <= '0;
                            col_q      <= '0;
                        end
                    end
                end
                ST_FINAL: begin
                    // Row-major walk of the upper triangle, one element per cycle.
                    if (issue_q) begin
                        if (issue_last) begin
                            issue_q <= 1'b0;
                        end else if (col_q == LAST_IDX) begin
                            row_q <= row_q + IDX_W'(1);
                            col_q <= row_q + IDX_W'(1);
                        end else begin
                            col_q <= col_q + IDX_W'(1);
                        end
                    end
                    if (el_last) done_pend_q <= 1'b1;
                    // cov_valid rises the cycle after the last matrix write lands.
                    if (done_pend_q) begin
                        state_q     <= ST_DONE;
                        done_pend_q <= 1'b0;
                        cov_valid_q <= 1'b1;
                        f_q         <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the accumulator arrays are plain flops, not a RAM, so loops clear them on reset and frame start.
    always_ff @(posedge clk) begin
        if (rst || frame_clear) begin
            for (int i = 0; i < SIZE_N; i++) begin
                sx_q[i] <= '0;
                for (int j = 0; j < SIZE_N; j++) sxy_q[i][j] <= '0;
            end
        end else if (xfer) begin
            for (int i = 0; i < SIZE_N; i++) begin
                sx_q[i] <= sx_q[i] + SX_W'(x[i]);
                for (int j = i; j < SIZE_N; j++) begin
                    sxy_q[i][j] <= sxy_q[i][j] + SXY_W'(PROD_W'(x[i]) * PROD_W'(x[j]));
                end
            end
        end
    end

    cov_element_calc #(
        .IDX_W        (IDX_W),
        .SX_W         (SX_W),
        .SXY_W        (SXY_W),
        .LOG2_SAMPLES (LOG2_SAMPLES),
        .FRAC_BITS    (FRAC_BITS),
        .COV_W        (COV_W)
    ) u_calc (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (issue_q),
        .last_i   (issue_last),
        .row_i    (row_q),
        .col_i    (col_q),
        .sx_row_i (sx_q[row_q]),
        .sx_col_i (sx_q[col_q]),
        .sxy_i    (sxy_q[row_q][col_q]),
        .valid_o  (el_valid),
        .last_o   (el_last),
        .row_o    (el_row),
        .col_o    (el_col),
        .cov_o    (el_cov)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cov_mat_q <= '0;
        end else if (el_valid) begin
            cov_mat_q[el_row][el_col] <= el_cov;
            cov_mat_q[el_col][el_row] <= el_cov;
        end
    end

    assign in_ready  = in_ready_q;
    assign cov_valid = cov_valid_q;
    assign f         = f_q;
    assign cov_mat   = cov_mat_q;

endmodule

// File: tb/tb_covariance_estimator.sv
// Bench for covariance_estimator: a small 2-channel/4-sample instance driven from a
// vector table, plus a default-size instance for the full-scale frame.
module tb_covariance_estimator;
    import ecg_pkg::*;

    localparam int SN  = 2;
    localparam int SL  = 2;
    localparam int SNS = 1 << SL;
    localparam int ST  = SN * (SN + 1) / 2;
    localparam int FN  = ECG_SIZE_N;
    localparam int FL  = ECG_LOG2_SAMPLES;
    localparam int FNS = 1 << FL;
    localparam int FT  = FN * (FN + 1) / 2;
    localparam int DW  = ECG_DATA_W;
    localparam int CW  = ECG_COV_W;
    localparam int FB  = ECG_FRAC_BITS;

    typedef struct packed {
        logic [3:0][DW-1:0] x0;
        logic [3:0][DW-1:0] x1;
        logic signed [63:0] c00;
        logic signed [63:0] c01;
        logic signed [63:0] c11;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic                           s_start, s_in_valid, s_in_ready, s_cov_valid, s_f;
    logic [SN-1:0][DW-1:0]          s_in_sample;
    logic [SN-1:0][SN-1:0][CW-1:0]  s_cov_mat;

    logic                           f_start, f_in_valid, f_in_ready, f_cov_valid, f_f;
    logic [FN-1:0][DW-1:0]          f_in_sample;
    logic [FN-1:0][FN-1:0][CW-1:0]  f_cov_mat;

    covariance_estimator #(
        .SIZE_N(SN), .DATA_W(DW), .LOG2_SAMPLES(SL), .FRAC_BITS(FB), .COV_W(CW)
    ) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_sample(s_in_sample), .cov_mat(s_cov_mat), .cov_valid(s_cov_valid), .f(s_f)
    );

    covariance_estimator dut_f (
        .clk(clk), .rst(rst), .start(f_start), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_sample(f_in_sample), .cov_mat(f_cov_mat), .cov_valid(f_cov_valid), .f(f_f)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic signed [63:0] model_cov(input int lg,
            input logic signed [127:0] sx_i, input logic signed [127:0] sx_j,
            input logic signed [127:0] sxy);
        logic signed [127:0] d;
        d = (sxy <<< lg) - sx_i * sx_j;
        d = (d <<< FB) >>> (2 * lg);
        return d[63:0];
    endfunction

    function automatic logic signed [63:0] s_elem(input int r, input int c);
        logic signed [CW-1:0] e;
        e = s_cov_mat[r][c];
        return 64'(e);
    endfunction

    function automatic logic signed [63:0] f_elem(input int r, input int c);
        logic signed [CW-1:0] e;
        e = f_cov_mat[r][c];
        return 64'(e);
    endfunction

    vec_t   vecs [4];
    vec_t   sb_q [$];
    longint fsb_q [$];
    vec_t   prev_v;
    bit     prev_ok = 1'b0;

    task automatic set_vec(input int idx, input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input longint c00, input longint c01, input longint c11);
        vecs[idx].x0  = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        vecs[idx].x1  = {DW'(b3), DW'(b2), DW'(b1), DW'(b0)};
        vecs[idx].c00 = c00;
        vecs[idx].c01 = c01;
        vecs[idx].c11 = c11;
    endtask

    // One frame on the small instance; gaps adds random in_valid holes, a stray
    // start during ACCUM and samples offered after the frame.
    task automatic run_small(input int idx, input bit gaps);
        vec_t v, e;
        bit   acc, rdy, seen;
        int   guard, n;
        v = vecs[idx];
        sb_q.push_back(v);
        s_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        check($sformatf("v%0d_ready_after_start", idx), s_in_ready, 1);
        check($sformatf("v%0d_valid_drop", idx), s_cov_valid, 0);
        if (prev_ok) begin
            check($sformatf("v%0d_hold_c00", idx), s_elem(0, 0), prev_v.c00);
            check($sformatf("v%0d_hold_c10", idx), s_elem(1, 0), prev_v.c01);
        end
        for (int k = 0; k < SNS; k++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 40) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    s_in_valid  = 1'b0;
                    s_in_sample = {DW'($urandom), DW'($urandom)};
                end else begin
                    s_in_valid  = 1'b1;
                    s_in_sample = {v.x1[k], v.x0[k]};
                end
                s_start = gaps && (k == 1) && (guard == 0);
                rdy = s_in_ready;
                @(posedge clk);
                acc = s_in_valid && rdy;
                @(negedge clk);
                s_start = 1'b0;
                guard++;
            end
            check($sformatf("v%0d_accept_s%0d", idx, k), acc, 1);
        end
        s_in_valid  = gaps;
        s_in_sample = {DW'(16'h7fff), DW'(16'h7fff)};
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = s_f;
            if (!seen) check($sformatf("v%0d_valid_early", idx), s_cov_valid, 0);
            check($sformatf("v%0d_ready_low", idx), s_in_ready, 0);
        end
        check($sformatf("v%0d_latency", idx), n, ST + 2);
        check($sformatf("v%0d_valid_on_f", idx), s_cov_valid, 1);
        e = sb_q.pop_front();
        check($sformatf("v%0d_c00", idx), s_elem(0, 0), e.c00);
        check($sformatf("v%0d_c01", idx), s_elem(0, 1), e.c01);
        check($sformatf("v%0d_c10", idx), s_elem(1, 0), e.c01);
        check($sformatf("v%0d_c11", idx), s_elem(1, 1), e.c11);
        @(negedge clk);
        check($sformatf("v%0d_f_single", idx), s_f, 0);
        check($sformatf("v%0d_valid_hold", idx), s_cov_valid, 1);
        check($sformatf("v%0d_c11_hold", idx), s_elem(1, 1), e.c11);
        s_in_valid = 1'b0;
        prev_v  = e;
        prev_ok = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     ra [4];
        int     rb [4];
        longint s0, s1, s00, s01, s11;
        longint fsx, fsxy;
        longint fexp;
        int     val, guard, n;
        bit     acc, rdy, seen;

        rst = 1'b1;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_sample = '0;
        f_start = 1'b0; f_in_valid = 1'b0; f_in_sample = '0;

        set_vec(0, 1, 3, 1, 3, 2, 2, 2, 2, 65536, 0, 0);
        set_vec(1, 1, -1, 1, -1, -1, 1, -1, 1, 65536, -65536, 65536);
        set_vec(2, 0, 0, 0, 1, 1, 0, 0, 0, 12288, -4096, 12288);
        s0 = 0; s1 = 0; s00 = 0; s01 = 0; s11 = 0;
        for (int k = 0; k < 4; k++) begin
            ra[k] = int'($urandom_range(0, 65535)) - 32768;
            rb[k] = int'($urandom_range(0, 65535)) - 32768;
            s0  += longint'(ra[k]);
            s1  += longint'(rb[k]);
            s00 += longint'(ra[k]) * longint'(ra[k]);
            s01 += longint'(ra[k]) * longint'(rb[k]);
            s11 += longint'(rb[k]) * longint'(rb[k]);
        end
        set_vec(3, ra[0], ra[1], ra[2], ra[3], rb[0], rb[1], rb[2], rb[3],
                model_cov(SL, s0, s0, s00), model_cov(SL, s0, s1, s01), model_cov(SL, s1, s1, s11));

        repeat (3) @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b1;
        check("rst_ready", s_in_ready, 0);
        check("rst_valid", s_cov_valid, 0);
        check("rst_f", s_f, 0);
        check("rst_mat_zero", 64'(|s_cov_mat), 0);
        check("rst_full_ready", f_in_ready, 0);
        check("rst_full_valid", f_cov_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready_low", s_in_ready, 0);
        s_in_valid = 1'b0;

        for (int i = 0; i < 4; i++) run_small(i, 1'b0);
        run_small(3, 1'b1);

        s_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_in_valid  = 1'b1;
            s_in_sample = {vecs[1].x1[k], vecs[1].x0[k]};
            @(posedge clk);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", s_in_ready, 0);
        check("midrst_valid", s_cov_valid, 0);
        check("midrst_f", s_f, 0);
        check("midrst_mat_zero", 64'(|s_cov_mat), 0);
        prev_ok = 1'b0;
        run_small(3, 1'b0);

        fsx  = 0;
        fsxy = 0;
        f_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_start = 1'b0;
        for (int k = 0; k < FNS; k++) begin
            val = (k % 2 == 0) ? 32767 : -32768;
            for (int c = 0; c < FN; c++) f_in_sample[c] = DW'(val);
            f_in_valid = 1'b1;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 8) begin
                rdy = f_in_ready;
                @(posedge clk);
                acc = rdy;
                @(negedge clk);
                guard++;
            end
            if (!acc) check($sformatf("full_accept_s%0d", k), acc, 1);
            fsx  += longint'(val);
            fsxy += longint'(val) * longint'(val);
        end
        f_in_valid = 1'b0;
        fsb_q.push_back(model_cov(FL, fsx, fsx, fsxy));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = f_f;
        end
        check("full_latency", n, FT + 2);
        check("full_valid", f_cov_valid, 1);
        fexp = fsb_q.pop_front();
        for (int r = 0; r < FN; r++) begin
            for (int c = 0; c < FN; c++) begin
                check($sformatf("full_c%0d%0d", r, c), f_elem(r, c), fexp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
